// File: rtl/usr_mem_engine_pkg.sv
// Shared constants and the shift-mode encoding for usr_mem_engine.
package usr_mem_engine_pkg;

  localparam int unsigned DATAWIDTH = 8;
  localparam int unsigned ADDRWIDTH = 4;
  localparam int unsigned WRITE_LAT = 2;
  localparam int unsigned READ_LAT  = 2;
  localparam int unsigned MODEW     = 3;

  typedef enum logic [MODEW-1:0] {
    HOLD  = 3'd0,
    LOAD  = 3'd1,
    SHR1  = 3'd2,
    SHL1  = 3'd3,
    ROR   = 3'd4,
    ROL   = 3'd5,
    ASR   = 3'd6,
    CLEAR = 3'd7
  } shift_mode_e;

endpackage

// File: rtl/usr_mem_engine_shift_core.sv
// Combinational next-state function of the universal shift register.
module usr_mem_engine_shift_core #(
  parameter int unsigned DATAWIDTH = usr_mem_engine_pkg::DATAWIDTH
) (
  input  logic [DATAWIDTH-1:0]                q,
  input  logic [usr_mem_engine_pkg::MODEW-1:0] s,
  input  logic [DATAWIDTH-1:0]                d,
  input  logic [$clog2(DATAWIDTH)-1:0]        shamt,
  input  logic                                msb_in,
  input  logic                                lsb_in,
  output logic [DATAWIDTH-1:0]                q_next
);
  import usr_mem_engine_pkg::*;

  shift_mode_e mode;

  // Select the next register value; a shift of DATAWIDTH bits yields zero,
  // so shamt == 0 leaves the rotates unchanged.
  always_comb begin
    mode   = shift_mode_e'(s);
    q_next = q;
    case (mode)
      HOLD:    q_next = q;
      LOAD:    q_next = d;
      SHR1:    q_next = {msb_in, q[DATAWIDTH-1:1]};
      SHL1:    q_next = {q[DATAWIDTH-2:0], lsb_in};
      ROR:     q_next = (q >> shamt) | (q << (DATAWIDTH - shamt));
      ROL:     q_next = (q << shamt) | (q >> (DATAWIDTH - shamt));
      ASR:     q_next = $signed(q) >>> shamt;
      CLEAR:   q_next = '0;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/usr_mem_engine.sv
// Shift register with a reservation-scheduled, latency-pipelined register file.
module usr_mem_engine #(
  parameter int unsigned DATAWIDTH = usr_mem_engine_pkg::DATAWIDTH,
  parameter int unsigned ADDRWIDTH = usr_mem_engine_pkg::ADDRWIDTH,
  parameter int unsigned WRITE_LAT = usr_mem_engine_pkg::WRITE_LAT,
  parameter int unsigned READ_LAT  = usr_mem_engine_pkg::READ_LAT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [DATAWIDTH-1:0]                D,
  input  logic [usr_mem_engine_pkg::MODEW-1:0] S,
  input  logic [$clog2(DATAWIDTH)-1:0]        SHAMT,
  input  logic                                MSBIn,
  input  logic                                LSBIn,
  input  logic [ADDRWIDTH-1:0]                addr,
  input  logic                                wr_en,
  input  logic                                rd_en,
  output logic                                wr_ack,
  output logic                                rd_ack,
  output logic [DATAWIDTH-1:0]                Q,
  output logic [DATAWIDTH-1:0]                dataout,
  output logic                                DataValid,
  output logic                                mem_wr_en,
  output logic [ADDRWIDTH-1:0]                mem_addr,
  output logic [DATAWIDTH-1:0]                mem_data
);
  import usr_mem_engine_pkg::*;

  localparam int unsigned DEPTH  = 2 ** ADDRWIDTH;
  localparam int unsigned RESV_L = (WRITE_LAT > READ_LAT) ? WRITE_LAT : READ_LAT;
  localparam int unsigned RESV_W = RESV_L + 1;

  logic [DATAWIDTH-1:0] q_q, q_next;
  logic [RESV_W-1:0]    resv_q, resv_d;
  logic [WRITE_LAT-1:0] wv_q, wv_d;
  logic [WRITE_LAT:0]   wv_all;
  logic [ADDRWIDTH-1:0] wa_q [WRITE_LAT];
  logic [ADDRWIDTH-1:0] wa_d [WRITE_LAT];
  logic [DATAWIDTH-1:0] wd_q [WRITE_LAT];
  logic [DATAWIDTH-1:0] wd_d [WRITE_LAT];
  logic [READ_LAT-1:0]  rv_q, rv_d;
  logic [READ_LAT:0]    rv_all;
  logic                 rd_slot_v;
  logic [ADDRWIDTH-1:0] rd_slot_addr;
  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [DATAWIDTH-1:0] mem_d [DEPTH];
  logic [ADDRWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATAWIDTH-1:0] mem_data_q, mem_data_d;
  logic [DATAWIDTH-1:0] dataout_q, dataout_d;

  usr_mem_engine_shift_core #(
    .DATAWIDTH(DATAWIDTH)
  ) u_shift_core (
    .q      (q_q),
    .s      (S),
    .d      (D),
    .shamt  (SHAMT),
    .msb_in (MSBIn),
    .lsb_in (LSBIn),
    .q_next (q_next)
  );

  // Reservation scheduler: bit k marks the port busy k cycles from now.
  // New claims are merged before the shift so they land one lower next cycle.
  always_comb begin
    wr_ack = wr_en & ~resv_q[WRITE_LAT];
    rd_ack = rd_en & ~resv_q[READ_LAT-1] & ~(wr_ack & (WRITE_LAT == READ_LAT - 1));
    resv_d = (resv_q
              | ({RESV_W{wr_ack}} & (RESV_W'(1) << WRITE_LAT))
              | ({RESV_W{rd_ack}} & (RESV_W'(1) << (READ_LAT - 1)))) >> 1;
  end

  // Write pipeline: stage k is the request accepted k+1 cycles ago.
  always_comb begin
    wv_all    = {wv_q, wr_ack};
    wv_d      = wv_all[WRITE_LAT-1:0];
    mem_wr_en = wv_all[WRITE_LAT];
    wa_d[0]   = addr;
    wd_d[0]   = q_next;
    for (int unsigned i = 1; i < WRITE_LAT; i++) begin
      wa_d[i] = wa_q[i-1];
      wd_d[i] = wd_q[i-1];
    end
  end

  // Read valid chain: index 0 is this cycle's accept, so READ_LAT-1 is the
  // port slot and READ_LAT is the DataValid cycle.
  always_comb begin
    rv_all    = {rv_q, rd_ack};
    rv_d      = rv_all[READ_LAT-1:0];
    rd_slot_v = rv_all[READ_LAT-1];
    DataValid = rv_all[READ_LAT];
  end

  if (READ_LAT == 1) begin : g_rd_direct
    // Read slot coincides with the request cycle.
    always_comb rd_slot_addr = addr;
  end else begin : g_rd_pipe
    logic [ADDRWIDTH-1:0] ra_q [READ_LAT-1];
    logic [ADDRWIDTH-1:0] ra_d [READ_LAT-1];

    // Delay the read address to its port slot.
    always_comb begin
      ra_d[0] = addr;
      for (int unsigned i = 1; i < READ_LAT - 1; i++) ra_d[i] = ra_q[i-1];
      rd_slot_addr = ra_q[READ_LAT-2];
    end

    // Read address pipeline registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned i = 0; i < READ_LAT - 1; i++) ra_q[i] <= '0;
      end else begin
        ra_q <= ra_d;
      end
    end
  end

  // Single memory port: commit a write or perform the slotted read.
  always_comb begin
    mem_d      = mem_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    dataout_d  = dataout_q;
    if (mem_wr_en) begin
      mem_addr_d                 = wa_q[WRITE_LAT-1];
      mem_data_d                 = wd_q[WRITE_LAT-1];
      mem_d[wa_q[WRITE_LAT-1]]   = wd_q[WRITE_LAT-1];
    end else if (rd_slot_v) begin
      mem_addr_d = rd_slot_addr;
      dataout_d  = mem_q[rd_slot_addr];
    end
  end

  // Output drive.
  always_comb begin
    Q        = q_q;
    dataout  = dataout_q;
    mem_addr = mem_addr_d;
    mem_data = mem_data_d;
  end

  // State registers; reset drops every in-flight request and clears the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q        <= '0;
      resv_q     <= '0;
      wv_q       <= '0;
      rv_q       <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      dataout_q  <= '0;
      for (int unsigned i = 0; i < WRITE_LAT; i++) begin
        wa_q[i] <= '0;
        wd_q[i] <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      q_q        <= q_next;
      resv_q     <= resv_d;
      wv_q       <= wv_d;
      rv_q       <= rv_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      dataout_q  <= dataout_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_usr_mem_engine.sv
// Self-checking bench for usr_mem_engine against an absolute-time reference model.
module tb_usr_mem_engine;
  import usr_mem_engine_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 4;
  localparam int unsigned WL  = 2;
  localparam int unsigned RL  = 2;
  localparam int unsigned SW  = $clog2(DW);
  localparam int unsigned DEP = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] D;
  logic [2:0]    S;
  logic [SW-1:0] SHAMT;
  logic          MSBIn, LSBIn;
  logic [AW-1:0] addr;
  logic          wr_en, rd_en;
  logic          wr_ack, rd_ack;
  logic [DW-1:0] Q, dataout, mem_data;
  logic          DataValid, mem_wr_en;
  logic [AW-1:0] mem_addr;

  usr_mem_engine #(
    .DATAWIDTH(DW),
    .ADDRWIDTH(AW),
    .WRITE_LAT(WL),
    .READ_LAT (RL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .D         (D),
    .S         (S),
    .SHAMT     (SHAMT),
    .MSBIn     (MSBIn),
    .LSBIn     (LSBIn),
    .addr      (addr),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wr_ack    (wr_ack),
    .rd_ack    (rd_ack),
    .Q         (Q),
    .dataout   (dataout),
    .DataValid (DataValid),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state, keyed by absolute cycle number.
  int            cyc = 0;
  logic [DW-1:0] m_q, m_dout, m_mdata;
  logic [AW-1:0] m_maddr;
  logic [DW-1:0] m_mem [DEP];
  bit            busy [int];
  bit            wc_v [int];
  logic [AW-1:0] wc_a [int];
  logic [DW-1:0] wc_d [int];
  bit            rs_v [int];
  logic [AW-1:0] rs_a [int];
  bit            dv_v [int];
  logic [DW-1:0] dv_d [int];
  logic          ack_w, ack_r;

  function automatic logic [DW-1:0] model_shift(input logic [DW-1:0] q, input logic [2:0] s,
                                                input logic [DW-1:0] d, input int unsigned sh,
                                                input logic mi, input logic li);
    logic [DW-1:0] r;
    r = q;
    case (shift_mode_e'(s))
      HOLD:  r = q;
      LOAD:  r = d;
      SHR1:  r = (q >> 1) | (DW'(mi) << (DW - 1));
      SHL1:  r = (q << 1) | DW'(li);
      ROR:   repeat (sh) r = {r[0], r[DW-1:1]};
      ROL:   repeat (sh) r = {r[DW-2:0], r[DW-1]};
      ASR:   repeat (sh) r = {r[DW-1], r[DW-1:1]};
      CLEAR: r = '0;
      default: r = q;
    endcase
    return r;
  endfunction

  task automatic model_clear();
    m_q = '0; m_dout = '0; m_mdata = '0; m_maddr = '0;
    for (int i = 0; i < DEP; i++) m_mem[i] = '0;
    busy.delete(); wc_v.delete(); wc_a.delete(); wc_d.delete();
    rs_v.delete(); rs_a.delete(); dv_v.delete(); dv_d.delete();
  endtask

  // Called mid-cycle: predict acks and port activity, compare, then advance.
  task automatic model_cycle();
    bit            e_wack, e_rack, e_we, e_dv;
    logic [DW-1:0] q_new;
    e_wack = wr_en && !busy.exists(cyc + WL);
    e_rack = rd_en && !busy.exists(cyc + RL - 1) && !(e_wack && (WL == RL - 1));
    q_new  = model_shift(m_q, S, D, SHAMT, MSBIn, LSBIn);
    if (e_wack) begin
      busy[cyc + WL] = 1'b1; wc_v[cyc + WL] = 1'b1;
      wc_a[cyc + WL] = addr; wc_d[cyc + WL] = q_new;
    end
    if (e_rack) begin
      busy[cyc + RL - 1] = 1'b1; rs_v[cyc + RL - 1] = 1'b1; rs_a[cyc + RL - 1] = addr;
    end
    e_we = wc_v.exists(cyc);
    if (e_we) begin
      m_maddr = wc_a[cyc]; m_mdata = wc_d[cyc];
    end else if (rs_v.exists(cyc)) begin
      m_maddr = rs_a[cyc];
      dv_v[cyc + 1] = 1'b1; dv_d[cyc + 1] = m_mem[rs_a[cyc]];
    end
    e_dv = dv_v.exists(cyc);
    if (e_dv) m_dout = dv_d[cyc];

    ack_w = wr_ack; ack_r = rd_ack;
    check_eq("wr_ack", wr_ack, e_wack);
    check_eq("rd_ack", rd_ack, e_rack);
    check_eq("Q", Q, m_q);
    check_eq("mem_wr_en", mem_wr_en, e_we);
    check_eq("mem_addr", mem_addr, m_maddr);
    check_eq("mem_data", mem_data, m_mdata);
    check_eq("DataValid", DataValid, e_dv);
    check_eq("dataout", dataout, m_dout);

    if (e_we) m_mem[wc_a[cyc]] = wc_d[cyc];
    m_q = q_new;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    S = HOLD; D = '0; SHAMT = '0; MSBIn = 1'b0; LSBIn = 1'b0;
    addr = '0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_Q", Q, 0);
      check_eq("rst_dataout", dataout, 0);
      check_eq("rst_DataValid", DataValid, 0);
      check_eq("rst_mem_wr_en", mem_wr_en, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_data", mem_data, 0);
    end
    model_clear();
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_clear();
    idle();
    apply_reset();

    // Read of a cleared word after reset.
    rd_en = 1'b1; addr = 4'd5; step();
    check_eq("rd5_ack", ack_r, 1);
    idle(); step();
    check_eq("rd5_dv", DataValid, 1);
    check_eq("rd5_data", dataout, 8'h00);

    // Load 0xA5 with write to addr 3, then read it back.
    S = LOAD; D = 8'hA5; wr_en = 1'b1; addr = 4'd3; step();
    check_eq("wr3_ack", ack_w, 1);
    idle(); step();
    check_eq("wr3_port_en", mem_wr_en, 1);
    check_eq("wr3_port_addr", mem_addr, 4'd3);
    check_eq("wr3_port_data", mem_data, 8'hA5);
    step();
    rd_en = 1'b1; addr = 4'd3; step();
    idle(); step();
    check_eq("rd3_dv", DataValid, 1);
    check_eq("rd3_data", dataout, 8'hA5);

    // Shift-mode spot values.
    S = ROR; SHAMT = 3'd3; step();
    check_eq("ror3", Q, 8'hB4);
    S = LOAD; D = 8'h96; step();
    S = ASR; SHAMT = 3'd2; step();
    check_eq("asr2", Q, 8'hE5);
    S = LOAD; D = 8'h02; step();
    S = SHR1; MSBIn = 1'b1; step();
    check_eq("shr1", Q, 8'h81);
    idle();

    // Read colliding with an earlier write's slot is rejected.
    wr_en = 1'b1; addr = 4'd1; step();
    check_eq("col_wr_ack", ack_w, 1);
    idle(); rd_en = 1'b1; addr = 4'd1; step();
    check_eq("col_rd_rej", ack_r, 0);
    step();
    check_eq("col_rd_ack", ack_r, 1);
    idle();
    check_eq("col_no_dv", DataValid, 0);
    step();
    check_eq("col_dv", DataValid, 1);
    check_eq("col_data", dataout, 8'h81);

    // Same-cycle write and read: read sees pre-write contents.
    S = LOAD; D = 8'h11; wr_en = 1'b1; addr = 4'd7; step();
    idle(); step(); step();
    S = LOAD; D = 8'h3C; wr_en = 1'b1; rd_en = 1'b1; addr = 4'd7; step();
    check_eq("sc_wr_ack", ack_w, 1);
    check_eq("sc_rd_ack", ack_r, 1);
    idle(); step();
    check_eq("sc_dv", DataValid, 1);
    check_eq("sc_data", dataout, 8'h11);
    step(); step();

    // Reset discards an in-flight write.
    S = LOAD; D = 8'h5A; wr_en = 1'b1; addr = 4'd9; step();
    check_eq("rw_wr_ack", ack_w, 1);
    apply_reset();
    rd_en = 1'b1; addr = 4'd9; step();
    idle(); step();
    check_eq("rw_dv", DataValid, 1);
    check_eq("rw_data", dataout, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) apply_reset();
      S     = 3'($urandom_range(0, 7));
      D     = DW'($urandom);
      SHAMT = SW'($urandom_range(0, DW - 1));
      MSBIn = 1'($urandom);
      LSBIn = 1'($urandom);
      addr  = AW'($urandom);
      wr_en = ($urandom_range(0, 99) < 45);
      rd_en = ($urandom_range(0, 99) < 50);
      step();
    end
    idle();
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
